// File: rtl/dual_port_ram_pkg.sv
// Shared encodings, clear-sequencer states and the byte-merge helper for dual_port_ram_bwe.
package dual_port_ram_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;
   localparam int RDW_NO_CHANGE   = 2;

   // Widest word the merge helper handles; callers zero-extend and slice back.
   localparam int MERGE_W  = 256;
   localparam int MERGE_NB = MERGE_W / 8;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } clr_state_e;

   function automatic logic [MERGE_W-1:0] byte_merge(
      input logic [MERGE_W-1:0]  old_w,
      input logic [MERGE_W-1:0]  new_w,
      input logic [MERGE_NB-1:0] mask
   );
      logic [MERGE_W-1:0] res;
      res = old_w;
      for (int k = 0; k < MERGE_NB; k++) begin
         if (mask[k]) res[8*k +: 8] = new_w[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: walks every word once writing zero, then hands the array to the ports.
module dpram_clear_seq
   import dual_port_ram_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  init_busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   clr_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         if (cnt_q == LAST) begin
            state_d = RUN;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Busy is also forced while reset is held so the ports never see a half-cleared array.
   assign init_busy = !rst_n || (state_q == CLEAR);
   assign clr_we    = (state_q == CLEAR);
   assign clr_addr  = cnt_q;

endmodule

// File: rtl/dual_port_ram_bwe.sv
// True dual-port RAM with byte write enables, read-valid strobes, RDW mode and collision flag.
// Optional extra output register stage: define DPRAM_OUT_REG_EN.
module dual_port_ram_bwe
   import dual_port_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 1 << ADDR_WIDTH,
   parameter int RDW_MODE   = RDW_READ_FIRST,
   localparam int NB        = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  init_busy,
   input  logic                  en_a,
   input  logic [NB-1:0]         we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   output logic [DATA_WIDTH-1:0] q_a,
   output logic                  valid_a,
   input  logic                  en_b,
   input  logic [NB-1:0]         we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] data_b,
   output logic [DATA_WIDTH-1:0] q_b,
   output logic                  valid_b,
   output logic                  collision
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  busy;
   logic                  run;
   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;

   dpram_clear_seq #(
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_clear (
      .clk      (clk),
      .rst_n    (rst_n),
      .init_busy(busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign run       = !busy;
   assign init_busy = busy;

   // Index 0 is port A, index 1 is port B.
   logic [1:0]                 en_p;
   logic [1:0][NB-1:0]         we_p;
   logic [1:0][ADDR_WIDTH-1:0] addr_p;
   logic [1:0][DATA_WIDTH-1:0] data_p;
   logic [1:0]                 wr_p;
   logic [1:0]                 valid_s1;
   logic [1:0][DATA_WIDTH-1:0] q_s1;

   assign en_p   = {en_b, en_a};
   assign we_p   = {we_b, we_a};
   assign addr_p = {addr_b, addr_a};
   assign data_p = {data_b, data_a};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         logic                  acc;
         logic                  in_range;
         logic [DATA_WIDTH-1:0] old_word;
         logic [DATA_WIDTH-1:0] wf_word;
         logic [MERGE_W-1:0]    merged;
         logic [DATA_WIDTH-1:0] q_d, q_q;
         logic                  valid_d, valid_q;

         assign acc      = run && en_p[gi];
         assign in_range = {1'b0, addr_p[gi]} < (ADDR_WIDTH+1)'(DEPTH);
         assign old_word = in_range ? mem[addr_p[gi]] : '0;
         assign merged   = byte_merge(MERGE_W'(old_word), MERGE_W'(data_p[gi]), MERGE_NB'(we_p[gi]));
         assign wf_word  = merged[DATA_WIDTH-1:0];
         assign wr_p[gi] = acc && in_range && (|we_p[gi]);

         if (DATA_WIDTH < MERGE_W) begin : g_hi
            logic unused_merge_hi;
            assign unused_merge_hi = ^merged[MERGE_W-1:DATA_WIDTH];
         end

         // The other port's same-cycle write is never visible here: old_word is the pre-edge array.
         always_comb begin
            q_d     = q_q;
            valid_d = 1'b0;
            if (acc) begin
               valid_d = 1'b1;
               if (!in_range) begin
                  q_d = '0;
               end else if (wr_p[gi] && (RDW_MODE == RDW_NO_CHANGE)) begin
                  valid_d = 1'b0;
               end else if (wr_p[gi] && (RDW_MODE == RDW_WRITE_FIRST)) begin
                  q_d = wf_word;
               end else begin
                  q_d = old_word;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               q_q     <= '0;
               valid_q <= 1'b0;
            end else begin
               q_q     <= q_d;
               valid_q <= valid_d;
            end
         end

         assign q_s1[gi]     = q_q;
         assign valid_s1[gi] = valid_q;
      end
   endgenerate

   logic coll_d, coll_q;

   always_comb begin
      coll_d = run && en_a && en_b && (addr_a == addr_b) && ((|we_a) || (|we_b));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) coll_q <= 1'b0;
      else        coll_q <= coll_d;
   end

   // Port B lanes are applied first so port A overrides any lane both ports write.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else begin
         for (int p = 1; p >= 0; p--) begin
            for (int k = 0; k < NB; k++) begin
               if (wr_p[p] && we_p[p][k]) mem[addr_p[p]][8*k +: 8] <= data_p[p][8*k +: 8];
            end
         end
      end
   end

`ifdef DPRAM_OUT_REG_EN
   logic [1:0][DATA_WIDTH-1:0] q_o_d, q_o_q;
   logic [1:0]                 valid_o_d, valid_o_q;
   logic                       coll_o_d, coll_o_q;

   always_comb begin
      q_o_d     = q_s1;
      valid_o_d = valid_s1;
      coll_o_d  = coll_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_o_q     <= '0;
         valid_o_q <= '0;
         coll_o_q  <= 1'b0;
      end else begin
         q_o_q     <= q_o_d;
         valid_o_q <= valid_o_d;
         coll_o_q  <= coll_o_d;
      end
   end

   assign q_a       = q_o_q[0];
   assign q_b       = q_o_q[1];
   assign valid_a   = valid_o_q[0];
   assign valid_b   = valid_o_q[1];
   assign collision = coll_o_q;
`else
   assign q_a       = q_s1[0];
   assign q_b       = q_s1[1];
   assign valid_a   = valid_s1[0];
   assign valid_b   = valid_s1[1];
   assign collision = coll_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_bwe.sv
// Bench for dual_port_ram_bwe: one instance per RDW mode, shared stimulus, array-based reference model.
module tb_dual_port_ram_bwe;

`ifdef DPRAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en   [2];
   logic [3:0]  we   [2];
   logic [3:0]  addr [2];
   logic [31:0] data [2];

   logic [31:0] q_a_o [3];
   logic [31:0] q_b_o [3];
   logic        valid_a_o [3];
   logic        valid_b_o [3];
   logic        coll_o [3];
   logic        busy_o [3];

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         dual_port_ram_bwe #(
            .DATA_WIDTH(32),
            .ADDR_WIDTH(4),
            .DEPTH     (16),
            .RDW_MODE  (gi)
         ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .init_busy(busy_o[gi]),
            .en_a     (en[0]),
            .we_a     (we[0]),
            .addr_a   (addr[0]),
            .data_a   (data[0]),
            .q_a      (q_a_o[gi]),
            .valid_a  (valid_a_o[gi]),
            .en_b     (en[1]),
            .we_b     (we[1]),
            .addr_b   (addr[1]),
            .data_b   (data[1]),
            .q_b      (q_b_o[gi]),
            .valid_b  (valid_b_o[gi]),
            .collision(coll_o[gi])
         );
      end
   endgenerate

   // Reference model state
   logic [31:0] mm [16];
   logic        m_busy;
   int          m_cnt;
   logic [31:0] s1q [2][3];
   logic [31:0] s2q [2][3];
   logic        s1v [2][3];
   logic        s2v [2][3];
   logic        s1c, s2c;

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic logic [31:0] expand(input logic [3:0] w);
      logic [31:0] m;
      for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{w[k]}};
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock: predict the edge from the model, then compare every instance.
   task automatic tick();
      logic        run;
      logic [31:0] nq [2][3];
      logic        nv [2][3];
      logic        nc;
      logic [31:0] old, mask;
      run = rst_n && !m_busy;
      for (int p = 0; p < 2; p++) begin
         old  = mm[addr[p]];
         mask = expand(we[p]);
         for (int m = 0; m < 3; m++) begin
            if (!rst_n) begin
               nq[p][m] = 32'h0; nv[p][m] = 1'b0;
            end else if (!run || !en[p]) begin
               nq[p][m] = s1q[p][m]; nv[p][m] = 1'b0;
            end else if (we[p] == 4'h0 || m == 0) begin
               nq[p][m] = old; nv[p][m] = 1'b1;
            end else if (m == 1) begin
               nq[p][m] = (old & ~mask) | (data[p] & mask); nv[p][m] = 1'b1;
            end else begin
               nq[p][m] = s1q[p][m]; nv[p][m] = 1'b0;
            end
         end
      end
      nc = run && en[0] && en[1] && (addr[0] == addr[1]) && (we[0] != 4'h0 || we[1] != 4'h0);
      if (run) begin
         if (en[1]) mm[addr[1]] = (mm[addr[1]] & ~expand(we[1])) | (data[1] & expand(we[1]));
         if (en[0]) mm[addr[0]] = (mm[addr[0]] & ~expand(we[0])) | (data[0] & expand(we[0]));
      end
      if (!rst_n) begin
         m_busy = 1'b1; m_cnt = 0;
      end else if (m_busy) begin
         mm[m_cnt] = 32'h0;
         if (m_cnt == 15) m_busy = 1'b0;
         else m_cnt++;
      end
      for (int p = 0; p < 2; p++) begin
         for (int m = 0; m < 3; m++) begin
            s2q[p][m] = rst_n ? s1q[p][m] : 32'h0;
            s2v[p][m] = rst_n ? s1v[p][m] : 1'b0;
            s1q[p][m] = nq[p][m];
            s1v[p][m] = nv[p][m];
         end
      end
      s2c = rst_n ? s1c : 1'b0;
      s1c = nc;
      @(posedge clk);
      #1;
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("q_a[m%0d]", m),       q_a_o[m],            (LAT == 1) ? s1q[0][m] : s2q[0][m]);
         chk($sformatf("valid_a[m%0d]", m),   32'(valid_a_o[m]),   32'((LAT == 1) ? s1v[0][m] : s2v[0][m]));
         chk($sformatf("q_b[m%0d]", m),       q_b_o[m],            (LAT == 1) ? s1q[1][m] : s2q[1][m]);
         chk($sformatf("valid_b[m%0d]", m),   32'(valid_b_o[m]),   32'((LAT == 1) ? s1v[1][m] : s2v[1][m]));
         chk($sformatf("collision[m%0d]", m), 32'(coll_o[m]),      32'((LAT == 1) ? s1c : s2c));
         chk($sformatf("init_busy[m%0d]", m), 32'(busy_o[m]),      32'(m_busy || !rst_n));
      end
   endtask

   task automatic wait_clear();
      int n;
      n = 0;
      while (busy_o[0] && n < 40) begin
         n++;
         tick();
      end
      chk("busy_cycles", 32'(n), 32'd16);
   endtask

   task automatic read_port(input int p, input logic [3:0] a, input logic [31:0] exp);
      en[p] = 1'b1; we[p] = 4'h0; addr[p] = a;
      tick();
      en[p] = 1'b0;
      repeat (LAT - 1) tick();
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("rd%0d_q[m%0d]@%0d", p, m, a), (p == 0) ? q_a_o[m] : q_b_o[m], exp);
         chk($sformatf("rd%0d_v[m%0d]@%0d", p, m, a), 32'((p == 0) ? valid_a_o[m] : valid_b_o[m]), 32'd1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int p = 0; p < 2; p++) begin
         en[p] = 1'b0; we[p] = 4'h0; addr[p] = 4'h0; data[p] = 32'h0;
         for (int m = 0; m < 3; m++) begin
            s1q[p][m] = 32'h0; s2q[p][m] = 32'h0; s1v[p][m] = 1'b0; s2v[p][m] = 1'b0;
         end
      end
      for (int i = 0; i < 16; i++) mm[i] = 32'h0;
      m_busy = 1'b1; m_cnt = 0; s1c = 1'b0; s2c = 1'b0;

      // Reset, clear, read every word
      repeat (3) tick();
      rst_n = 1'b1;
      wait_clear();
      for (int a = 0; a < 16; a++) read_port(0, 4'(a), 32'h0);

      // Byte-lane write then cross-port read
      en[0] = 1'b1; we[0] = 4'hF; addr[0] = 4'd3; data[0] = 32'hAABBCCDD;
      tick();
      we[0] = 4'b0101; data[0] = 32'h11223344;
      tick();
      en[0] = 1'b0; we[0] = 4'h0;
      read_port(1, 4'd3, 32'hAA22CC44);

      // Read-during-write per mode
      en[0] = 1'b1; we[0] = 4'hF; addr[0] = 4'd5; data[0] = 32'h1;
      tick();
      data[0] = 32'h2;
      tick();
      en[0] = 1'b0; we[0] = 4'h0;
      repeat (LAT - 1) tick();
      chk("rdw_read_first_q", q_a_o[0], 32'h1);
      chk("rdw_write_first_q", q_a_o[1], 32'h2);
      chk("rdw_no_change_v", 32'(valid_a_o[2]), 32'd0);
      read_port(0, 4'd5, 32'h2);

      // Cross-port collision on one address
      en[0] = 1'b1; we[0] = 4'b0001; addr[0] = 4'd7; data[0] = 32'h000000FF;
      en[1] = 1'b1; we[1] = 4'b0011; addr[1] = 4'd7; data[1] = 32'h0000AB00;
      tick();
      en[0] = 1'b0; en[1] = 1'b0; we[0] = 4'h0; we[1] = 4'h0;
      repeat (LAT - 1) tick();
      chk("collision_pulse", 32'(coll_o[0]), 32'd1);
      tick();
      chk("collision_drop", 32'(coll_o[0]), 32'd0);
      read_port(0, 4'd7, 32'h0000ABFF);

      // Randomised traffic, collisions biased in
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            en[p]   = 1'($urandom_range(0, 3) != 0);
            we[p]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            addr[p] = 4'($urandom_range(0, 15));
            data[p] = $urandom;
         end
         if ($urandom_range(0, 3) == 0) addr[1] = addr[0];
         tick();
      end
      en[0] = 1'b0; en[1] = 1'b0; we[0] = 4'h0; we[1] = 4'h0;
      repeat (LAT) tick();

      // Reset in the middle of a clear
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_clear();
      for (int a = 0; a < 16; a++) read_port(1, 4'(a), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dual_port_ram_bwe.md
# dual_port_ram_bwe

True dual-port synchronous RAM, successor to the team's basic dual-port RAM. Adds byte-granular write enables, per-port access enables with a read-valid strobe, and a selectable read-during-write mode. Same-address collisions between the two ports resolve deterministically and are flagged. A built-in clear sequencer zeroes the array after reset. Used as the shared buffer between producer/consumer datapaths and as the storage core for FIFOs and mailboxes.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8
- ADDR_WIDTH, 4, address width
- DEPTH, 1<<ADDR_WIDTH, number of words; DEPTH ≤ 2^ADDR_WIDTH
- RDW_MODE, 0, same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- NB (derived), DATA_WIDTH/8, byte lanes

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- init_busy  out  1  high while the array is being cleared; ports ignored
- en_a / en_b  in  1  port access enable
- we_a / we_b  in  NB  byte write enables; ignored unless en is high
- addr_a / addr_b  in  ADDR_WIDTH  word address
- data_a / data_b  in  DATA_WIDTH  write data
- q_a / q_b  out  DATA_WIDTH  read data
- valid_a / valid_b  out  1  q holds fresh read data this cycle
- collision  out  1  one-cycle pulse on a same-address access with at least one write

## Operation
- Clear sequencer states: CLEAR, RUN.
  - rst_n low forces CLEAR with counter = 0.
  - CLEAR writes 0 to word[counter] and increments each cycle. After word DEPTH-1 it moves to RUN, so CLEAR lasts exactly DEPTH cycles after rst_n rises.
  - Reset asserted mid-CLEAR restarts the clear at 0.
- init_busy = 1 in CLEAR (including while rst_n is low) and 0 in RUN. During CLEAR: en/we ignored, valid stays 0.
- In RUN, an access occurs when en_x = 1.
  - Each byte lane k with we_x[k] = 1 is written from data_x[8k+7:8k].
  - A read occurs on every access.
  - en_x = 0: q_x holds its value and valid_x = 0.
- Same-port read-during-write (any we bit set):
  - READ_FIRST: q = old word.
  - WRITE_FIRST: q = merged new word.
  - NO_CHANGE: q holds its value and valid = 0.
- Cross-port collision: en_a & en_b, addr_a == addr_b, and (|we_a | |we_b).
  - Per lane written by both ports, port A wins. Lanes written by one port take that port's data.
  - A port reading the collided address sees the other port's write as old data; its own write follows RDW_MODE.
  - collision pulses for 1 cycle, aligned with valid.
- Addresses ≥ DEPTH: the write is dropped, q = 0, valid = 1.
- Reset values: q_a = q_b = 0, valid_a = valid_b = 0, collision = 0, init_busy = 1. Array contents become 0 only via CLEAR.

## Timing
- Base read latency is 1 cycle: access at edge N gives q/valid after edge N+1, visible in cycle N+1.
- Write visible to either port's read in the cycle after the write edge.
- valid and collision share the q latency, including the extra stage when DPRAM_OUT_REG_EN is defined.
- First accepted access is in the first cycle with init_busy = 0.
- No back-pressure: one access per port per cycle, sustained.

## Configuration
- DPRAM_OUT_REG_EN defined: an extra output register on q_x, valid_x and collision.
  - Read latency becomes 2 cycles.
  - The stage is reset to 0 like the outputs.
  - NO_CHANGE holds the registered value.
- Not defined: latency 1, no extra stage.

## Structure
- dual_port_ram_pkg holds:
  - RDW_MODE encodings (RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1, RDW_NO_CHANGE = 2)
  - a byte-merge function (old word, new data, mask) → word
- Sub-module dpram_clear_seq: the CLEAR/RUN state, address counter and init_busy; it drives the array write mux during CLEAR.
- Array, port logic, collision resolution and the optional output stage live in the top module.

## Test plan
Defaults unless stated otherwise; expected latencies are for DPRAM_OUT_REG_EN undefined.
- Reset then clear: hold rst_n low 3 cycles, release, read every address on A.
  - init_busy high for exactly 16 cycles after release.
  - All q_a = 0x00000000, valid_a = 1 one cycle after each read.
- Byte write: A writes 0xAABBCCDD to addr 3 with we = 4'b1111, then 0x11223344 with we = 4'b0101; B reads addr 3.
  - q_b = 0xAA22CC44 one cycle later.
- RDW mode: word 5 = 0x1; A writes 0x2 to addr 5 while reading.
  - READ_FIRST: q_a = 0x1.
  - WRITE_FIRST: q_a = 0x2.
  - NO_CHANGE: q_a unchanged and valid_a = 0.
  - Next read returns 0x2 in all modes.
- Collision: same cycle, A writes 0x000000FF we = 4'b0001 and B writes 0x0000AB00 we = 4'b0011, both to addr 7.
  - collision = 1 for one cycle.
  - A subsequent read of addr 7 returns 0x0000ABFF.
- Reset mid-clear: deassert rst_n, wait 5 cycles, assert for 1 cycle, release.
  - init_busy stays high 16 more cycles.
  - All words read 0.
- DPRAM_OUT_REG_EN defined: repeat the byte-write test.
  - q_b = 0xAA22CC44 and valid_b = 1 exactly 2 cycles after the read.
  - Back-to-back reads of addr 0..15 stream at 1 word/cycle.
